// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the renderer stages and the VGA connector.
// The master side drives every signal; the slave side only observes.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX,
    output DrawY,
    output blank,
    output hs,
    output vs,
    output line_start,
    output frame_start,
    output frame_count
  );

  modport slave (
    input DrawX,
    input DrawY,
    input blank,
    input hs,
    input vs,
    input line_start,
    input frame_start,
    input frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster timing generator on vga_clk (default parameters).
// Define VGA_SYNC_DELAY_EN to delay blank/hs/vs by one clock to match renderer ROM latency.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       blank_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       line_nxt;
  logic       frame_nxt;

  logic       blank_r;
  logic       hs_r;
  logic       vs_r;
  logic       line_r;
  logic       frame_r;
  logic [7:0] frame_cnt;

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + 10'd1;
      end
    end
  end

  // Decoding the next-state counters keeps every registered output aligned with DrawX/DrawY.
  always_comb begin
    blank_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hs_nxt    = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt    = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    line_nxt  = (h_nxt == '0);
    frame_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      blank_r   <= 1'b0;
      hs_r      <= ~SYNC_POL;
      vs_r      <= ~SYNC_POL;
      line_r    <= 1'b0;
      frame_r   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      blank_r <= blank_nxt;
      hs_r    <= hs_nxt;
      vs_r    <= vs_nxt;
      line_r  <= line_nxt;
      frame_r <= frame_nxt;
      if (frame_nxt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign vga.DrawX       = h_cnt;
  assign vga.DrawY       = v_cnt;
  assign vga.line_start  = line_r;
  assign vga.frame_start = frame_r;
  assign vga.frame_count = frame_cnt;

`ifdef VGA_SYNC_DELAY_EN
  logic blank_d;
  logic hs_d;
  logic vs_d;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank_d <= 1'b0;
      hs_d    <= ~SYNC_POL;
      vs_d    <= ~SYNC_POL;
    end else begin
      blank_d <= blank_r;
      hs_d    <= hs_r;
      vs_d    <= vs_r;
    end
  end

  assign vga.blank = blank_d;
  assign vga.hs    = hs_d;
  assign vga.vs    = vs_d;
`else
  assign vga.blank = blank_r;
  assign vga.hs    = hs_r;
  assign vga.vs    = vs_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance plus a tiny-raster instance
// (active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  localparam int BHV = 8;
  localparam int BHF = 2;
  localparam int BHS = 3;
  localparam int BHB = 3;
  localparam int BVV = 6;
  localparam int BVF = 2;
  localparam int BVS = 2;
  localparam int BVB = 2;
  localparam bit BPOL = 1'b1;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    bit   rst_n;
    int   ncyc;
    obs_t e;
  } vec_t;

  logic vga_clk = 1'b0;
  logic rst_a   = 1'b0;
  logic rst_b   = 1'b0;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen u_a (
    .vga_clk (vga_clk),
    .reset_n (rst_a),
    .vga     (if_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (BHV), .H_FRONT (BHF), .H_SYNC (BHS), .H_BACK (BHB),
    .V_VISIBLE (BVV), .V_FRONT (BVF), .V_SYNC (BVS), .V_BACK (BVB),
    .SYNC_POL  (BPOL)
  ) u_b (
    .vga_clk (vga_clk),
    .reset_n (rst_b),
    .vga     (if_b)
  );

  obs_t live_a;
  obs_t live_b;
  assign live_a = {if_a.DrawX, if_a.DrawY, if_a.blank, if_a.hs, if_a.vs,
                   if_a.line_start, if_a.frame_start, if_a.frame_count};
  assign live_b = {if_b.DrawX, if_b.DrawY, if_b.blank, if_b.hs, if_b.vs,
                   if_b.line_start, if_b.frame_start, if_b.frame_count};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  obs_t al_a, al_b, dl_a, dl_b;
  obs_t sb_a[$];
  obs_t sb_b[$];

  function automatic obs_t mk(int x, int y, bit b, bit h, bit v, bit l, bit f, int c);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v;
    o.ls = l; o.fs = f; o.fc = 8'(c);
    return o;
  endfunction

  // Reference raster: one pixel-clock edge of the aligned outputs.
  function automatic obs_t model_step(obs_t al, bit rn, int hv, int hf, int hsw, int hb,
                                      int vv, int vf, int vsw, int vb, bit pol);
    obs_t n;
    int ht, vt, x, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (!rn) return mk(0, 0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 0);
    x = int'(al.x);
    y = int'(al.y);
    if (x == ht - 1) begin
      x = 0;
      y = (y == vt - 1) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
    n.x     = 10'(x);
    n.y     = 10'(y);
    n.blank = (x < hv) && (y < vv);
    n.hs    = (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol;
    n.vs    = (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol;
    n.ls    = (x == 0);
    n.fs    = (x == 0) && (y == 0);
    n.fc    = n.fs ? al.fc + 8'd1 : al.fc;
    return n;
  endfunction

  function automatic obs_t delayed(obs_t prev_al, bit rn, bit pol);
    obs_t d;
    d = prev_al;
    if (!rn) begin
      d.blank = 1'b0; d.hs = ~pol; d.vs = ~pol;
    end
    return d;
  endfunction

  function automatic obs_t expect_of(obs_t al, obs_t dl);
    obs_t e;
    e = al;
    if (DLY) begin
      e.blank = dl.blank; e.hs = dl.hs; e.vs = dl.vs;
    end
    return e;
  endfunction

  task automatic cmp_obs(string name, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               name, cyc, got.x, got.y, got.blank, got.hs, got.vs, got.ls, got.fs, got.fc,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock: drive resets, push model expectation, then pop and compare after the edge.
  task automatic step(bit ra, bit rb);
    obs_t na, nb;
    @(negedge vga_clk);
    rst_a = ra;
    rst_b = rb;
    na   = model_step(al_a, ra, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    dl_a = delayed(al_a, ra, 1'b0);
    al_a = na;
    sb_a.push_back(expect_of(al_a, dl_a));
    nb   = model_step(al_b, rb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BPOL);
    dl_b = delayed(al_b, rb, BPOL);
    al_b = nb;
    sb_b.push_back(expect_of(al_b, dl_b));
    @(posedge vga_clk);
    #1;
    cyc++;
    cmp_obs("sb_a", live_a, sb_a.pop_front());
    cmp_obs("sb_b", live_b, sb_b.pop_front());
  endtask

  vec_t vt[13];

  initial begin
    int   last_ls, hs_run, last_fs, vs_run;
    bit   prev_hs, prev_blank, prev_vs, vs_armed, found;
    logic [7:0] last_fc;

    al_a = mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    al_b = mk(0, 0, 1'b0, ~BPOL, ~BPOL, 1'b0, 1'b0, 0);
    dl_a = al_a;
    dl_b = al_b;

    vt[0]  = '{1'b0, 5,   mk(0,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[1]  = '{1'b1, 1,   mk(1,   0, !DLY, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[2]  = '{1'b1, 638, mk(639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[3]  = '{1'b1, 1,   mk(640, 0, DLY,  1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[4]  = '{1'b1, 16,  mk(656, 0, 1'b0, DLY,  1'b1, 1'b0, 1'b0, 0)};
    vt[5]  = '{1'b1, 95,  mk(751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0)};
    vt[6]  = '{1'b1, 1,   mk(752, 0, 1'b0, !DLY, 1'b1, 1'b0, 1'b0, 0)};
    vt[7]  = '{1'b1, 47,  mk(799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[8]  = '{1'b1, 1,   mk(0,   1, !DLY, 1'b1, 1'b1, 1'b1, 1'b0, 0)};
    vt[9]  = '{1'b1, 300, mk(300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[10] = '{1'b0, 1,   mk(0,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[11] = '{1'b1, 1,   mk(1,   0, !DLY, 1'b1, 1'b1, 1'b0, 1'b0, 0)};
    vt[12] = '{1'b1, 799, mk(0,   1, !DLY, 1'b1, 1'b1, 1'b1, 1'b0, 0)};

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < vt[i].ncyc; k++) step(vt[i].rst_n, vt[i].rst_n);
      cmp_obs($sformatf("vec%0d", i), live_a, vt[i].e);
    end

    // Line and frame periodicity, sync widths and where each strobe first moves.
    last_ls = -1; hs_run = 0; prev_hs = 1'b1; prev_blank = 1'b1;
    last_fs = -1; vs_run = 0; prev_vs = ~BPOL; vs_armed = 1'b0; last_fc = '0;
    for (int c = 0; c < 1600; c++) begin
      step(1'b1, 1'b1);
      if (live_a.ls) begin
        if (last_ls >= 0) chk("ls_period", 32'(c - last_ls), 32'd800);
        last_ls = c;
      end
      if (live_a.hs == 1'b0) begin
        if (prev_hs) chk("hs_fall_x", 32'(live_a.x), DLY ? 32'd657 : 32'd656);
        hs_run++;
      end else if (!prev_hs) begin
        chk("hs_low_len", 32'(hs_run), 32'd96);
        hs_run = 0;
      end
      prev_hs = live_a.hs;
      if (!live_a.blank && prev_blank) chk("blank_fall_x", 32'(live_a.x), DLY ? 32'd641 : 32'd640);
      prev_blank = live_a.blank;

      if (live_b.fs) begin
        if (last_fs >= 0) begin
          chk("fs_period", 32'(c - last_fs), 32'(BHT * BVT));
          chk("fc_inc", 32'(live_b.fc), 32'(8'(last_fc + 8'd1)));
        end
        last_fs = c;
        last_fc = live_b.fc;
        if (!vs_armed) begin
          vs_armed = 1'b1;
          prev_vs  = live_b.vs;
        end
      end
      if (vs_armed) begin
        if (live_b.vs == BPOL) begin
          if (prev_vs != BPOL) begin
            chk("vs_start_x", 32'(live_b.x), DLY ? 32'd1 : 32'd0);
            chk("vs_start_y", 32'(live_b.y), 32'(BVV + BVF));
          end
          vs_run++;
        end else if (prev_vs == BPOL) begin
          chk("vs_len", 32'(vs_run), 32'(BVS * BHT));
          vs_run = 0;
        end
        prev_vs = live_b.vs;
      end
    end

    // Frame wrap edge on the small raster.
    found = 1'b0;
    for (int k = 0; k < 2 * BHT * BVT && !found; k++) begin
      if (live_b.x == 10'(BHT - 1) && live_b.y == 10'(BVT - 1)) found = 1'b1;
      else step(1'b1, 1'b1);
    end
    chk("wrap_reach", 32'(found), 32'd1);
    last_fc = live_b.fc;
    step(1'b1, 1'b1);
    chk("wrap_x", 32'(live_b.x), 32'd0);
    chk("wrap_y", 32'(live_b.y), 32'd0);
    chk("wrap_fs", 32'(live_b.fs), 32'd1);
    chk("wrap_ls", 32'(live_b.ls), 32'd1);
    chk("wrap_blank", 32'(live_b.blank), DLY ? 32'd0 : 32'd1);
    chk("wrap_fc", 32'(live_b.fc), 32'(8'(last_fc + 8'd1)));

    // Single-cycle reset in the middle of a visible line.
    found = 1'b0;
    for (int k = 0; k < 2 * BHT * BVT && !found; k++) begin
      if (live_b.x == 10'd5 && live_b.y == 10'd3) found = 1'b1;
      else step(1'b1, 1'b1);
    end
    chk("mid_reach", 32'(found), 32'd1);
    step(1'b1, 1'b0);
    cmp_obs("mid_rst", live_b, mk(0, 0, 1'b0, ~BPOL, ~BPOL, 1'b0, 1'b0, 0));
    step(1'b1, 1'b1);
    cmp_obs("mid_rel", live_b, mk(1, 0, !DLY, ~BPOL, ~BPOL, 1'b0, 1'b0, 0));
    found = 1'b0;
    for (int k = 0; k < 2 * BHT * BVT && !found; k++) begin
      step(1'b1, 1'b1);
      if (live_b.fs) found = 1'b1;
    end
    chk("mid_fs_seen", 32'(found), 32'd1);
    chk("mid_fc", 32'(live_b.fc), 32'd1);
    chk("mid_fs_pos", 32'({live_b.x, live_b.y}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
